// File: rtl/cons_pkg.sv
// Shared definitions for the consumer buffer: FSM state encoding and default sizing.
package cons_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      PROC = 2'b01,
      DONE = 2'b10
   } state_t;

   localparam int DEF_DEPTH     = 8;
   localparam int DEF_W         = 8;
   localparam int DEF_PROC_BASE = 1;

endpackage

// File: rtl/cons_buf_if.sv
// Producer-to-consumer stream: a strobe plus a data word, with no backpressure path.
interface cons_buf_if #(
   parameter int W = 8
);
   logic         val;
   logic [W-1:0] data;

   modport master (output val, output data);
   modport slave  (input  val, input  data);
endinterface

// File: rtl/cons_buf_sfifo.sv
// Circular FIFO with registered occupancy; read data is the current head (no fall-through).
module sfifo #(
   parameter int DEPTH = 8,
   parameter int W     = 8
) (
   input  logic                     clk,
   input  logic                     rst_b,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             wdata,
   output logic [W-1:0]             rdata,
   output logic [$clog2(DEPTH):0]   lvl,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   // Storage carries no reset; entries are only meaningful while counted in lvl.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         lvl    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   lvl <= lvl + (AW+1)'(1);
            2'b01:   lvl <= lvl - (AW+1)'(1);
            default: lvl <= lvl;
         endcase
      end
   end

   assign rdata = mem[rd_ptr];
   assign full  = (lvl == FULL_LVL);
   assign empty = (lvl == '0);

endmodule

// File: rtl/cons_buf.sv
// Consumer stage: buffers the producer stream and services each word for a data-dependent time.
//
//   state | meaning
//   IDLE  | waiting; pops the head word when the FIFO is not empty
//   PROC  | service timer counting down to zero
//   DONE  | ack pulse; word is summed and counted on exit
module cons_buf
   import cons_pkg::*;
#(
   parameter int DEPTH     = DEF_DEPTH,
   parameter int W         = DEF_W,
   parameter int PROC_BASE = DEF_PROC_BASE
) (
   input  logic                   clk,
   input  logic                   rst_b,
   cons_buf_if.slave              in_if,
   output logic [15:0]            sum,
   output logic [7:0]             cnt,
   output logic [$clog2(DEPTH):0] lvl,
   output logic                   ovf,
   output logic                   busy,
   output logic                   ack
);

   // Wide enough for the largest load, PROC_BASE + 3.
   localparam int TW = $clog2(PROC_BASE + 4);

   state_t        state_q, state_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [W-1:0]  cur_q, cur_d;
   logic          pop;
   logic          push;
   logic          drop;
   logic          acc;
   logic [W-1:0]  rdata;
   logic          full;
   logic          empty;

   sfifo #(
      .DEPTH (DEPTH),
      .W     (W)
   ) u_fifo (
      .clk   (clk),
      .rst_b (rst_b),
      .push  (push),
      .pop   (pop),
      .wdata (in_if.data),
      .rdata (rdata),
      .lvl   (lvl),
      .full  (full),
      .empty (empty)
   );

   // A full FIFO still accepts a word when the head leaves on the same edge.
   assign push = in_if.val && (!full || pop);
   assign drop = in_if.val && full && !pop;

   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      cur_d   = cur_q;
      pop     = 1'b0;
      acc     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               cur_d   = rdata;
               tmr_d   = TW'(PROC_BASE) + TW'(rdata[1:0]);
               state_d = PROC;
            end
         end
         PROC: begin
            if (tmr_q == '0) state_d = DONE;
            else             tmr_d   = tmr_q - TW'(1);
         end
         DONE: begin
            acc     = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q <= IDLE;
         tmr_q   <= '0;
         cur_q   <= '0;
         sum     <= '0;
         cnt     <= '0;
         ovf     <= 1'b0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         cur_q   <= cur_d;
         if (acc) begin
            sum <= sum + 16'(cur_q);
            cnt <= cnt + 8'd1;
         end
         if (drop) ovf <= 1'b1;
      end
   end

   assign busy = (state_q != IDLE);
   assign ack  = (state_q == DONE);

endmodule

// File: tb/tb_cons_buf.sv
// Directed bench for cons_buf: reset, single word timing, overflow, full+pop, sum wrap, mid-run reset.
module tb_cons_buf;

   logic        clk;
   logic        rst_b;
   logic [15:0] sum;
   logic [7:0]  cnt;
   logic [3:0]  lvl;
   logic        ovf;
   logic        busy;
   logic        ack;

   int n_chk;
   int n_pass;
   int ack_seen;

   cons_buf_if #(.W(8)) bus ();

   cons_buf #(.DEPTH(8), .W(8), .PROC_BASE(1)) dut (
      .clk   (clk),
      .rst_b (rst_b),
      .in_if (bus),
      .sum   (sum),
      .cnt   (cnt),
      .lvl   (lvl),
      .ovf   (ovf),
      .busy  (busy),
      .ack   (ack)
   );

   // Rising edges at 10, 20, 30 ...; falling edges at 5, 15, 25 ...
   initial clk = 1'b1;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_b = 1'b0;
      #10;
      rst_b = 1'b1;
      step();
   endtask

   initial begin
      n_chk    = 0;
      n_pass   = 0;
      ack_seen = 0;
      rst_b    = 1'b0;
      bus.val  = 1'b0;
      bus.data = 8'h00;

      // Reset state
      #12;
      chk("rst_sum", 32'(sum), 32'h0);
      chk("rst_cnt", 32'(cnt), 32'h0);
      chk("rst_lvl", 32'(lvl), 32'h0);
      chk("rst_ovf", 32'(ovf), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_ack", 32'(ack), 32'h0);
      #13;
      rst_b = 1'b1;
      repeat (3) step();
      chk("post_rst_lvl", 32'(lvl), 32'h0);
      chk("post_rst_busy", 32'(busy), 32'h0);
      chk("post_rst_sum", 32'(sum), 32'h0);

      // Single word 0x05: service 5 cycles
      bus.val = 1'b1; bus.data = 8'h05;
      step();
      bus.val = 1'b0;
      chk("s_lvl_k", 32'(lvl), 32'h1);
      chk("s_busy_k", 32'(busy), 32'h0);
      step();
      chk("s_lvl_k1", 32'(lvl), 32'h0);
      chk("s_busy_k1", 32'(busy), 32'h1);
      step();
      step();
      chk("s_ack_k3", 32'(ack), 32'h0);
      step();
      chk("s_ack_k4", 32'(ack), 32'h1);
      chk("s_sum_k4", 32'(sum), 32'h0);
      step();
      chk("s_ack_k5", 32'(ack), 32'h0);
      chk("s_sum_k5", 32'(sum), 32'h5);
      chk("s_cnt_k5", 32'(cnt), 32'h1);
      chk("s_busy_k5", 32'(busy), 32'h0);

      // Burst of 12 x 0x04 with one drop
      do_reset();
      for (int i = 0; i < 12; i++) begin
         bus.val = 1'b1; bus.data = 8'h04;
         step();
         if (i == 1)  chk("b_lvl_k1", 32'(lvl), 32'h1);
         if (i == 8)  chk("b_lvl_k8", 32'(lvl), 32'h7);
         if (i == 9)  chk("b_lvl_k9", 32'(lvl), 32'h7);
         if (i == 10) begin
            chk("b_lvl_k10", 32'(lvl), 32'h8);
            chk("b_ovf_k10", 32'(ovf), 32'h0);
         end
         if (i == 11) begin
            chk("b_lvl_k11", 32'(lvl), 32'h8);
            chk("b_ovf_k11", 32'(ovf), 32'h1);
         end
      end
      bus.val = 1'b0;
      repeat (60) step();
      chk("b_cnt", 32'(cnt), 32'd11);
      chk("b_sum", 32'(sum), 32'h2C);
      chk("b_lvl_end", 32'(lvl), 32'h0);
      chk("b_ovf_sticky", 32'(ovf), 32'h1);

      // Full FIFO with a write on the pop edge
      do_reset();
      for (int i = 0; i < 11; i++) begin
         bus.val = 1'b1; bus.data = 8'h04;
         step();
      end
      bus.val = 1'b0;
      step();
      step();
      chk("f_lvl_full", 32'(lvl), 32'h8);
      bus.val = 1'b1; bus.data = 8'h04;
      step();
      bus.val = 1'b0;
      chk("f_lvl_pop", 32'(lvl), 32'h8);
      chk("f_ovf", 32'(ovf), 32'h0);
      repeat (60) step();
      chk("f_cnt", 32'(cnt), 32'd12);
      chk("f_sum", 32'(sum), 32'h30);
      chk("f_ovf_end", 32'(ovf), 32'h0);

      // Sum wrap with 0xFF words paced every 8 cycles
      do_reset();
      for (int i = 0; i < 257; i++) begin
         bus.val = 1'b1; bus.data = 8'hFF;
         step();
         bus.val = 1'b0;
         repeat (7) step();
      end
      chk("w_sum_257", 32'(sum), 32'hFFFF);
      chk("w_cnt_257", 32'(cnt), 32'h01);
      bus.val = 1'b1; bus.data = 8'hFF;
      step();
      bus.val = 1'b0;
      repeat (7) step();
      chk("w_sum_258", 32'(sum), 32'h00FE);
      chk("w_cnt_258", 32'(cnt), 32'h02);
      chk("w_ovf", 32'(ovf), 32'h0);

      // Reset mid-PROC with lvl=5 and nonzero accumulators
      for (int i = 0; i < 6; i++) begin
         bus.val = 1'b1; bus.data = 8'h03;
         step();
      end
      bus.val = 1'b0;
      chk("r_lvl_pre", 32'(lvl), 32'h5);
      chk("r_busy_pre", 32'(busy), 32'h1);
      @(negedge clk);
      rst_b = 1'b0;
      #1;
      chk("r_sum_async", 32'(sum), 32'h0);
      chk("r_cnt_async", 32'(cnt), 32'h0);
      chk("r_lvl_async", 32'(lvl), 32'h0);
      chk("r_busy_async", 32'(busy), 32'h0);
      chk("r_ack_async", 32'(ack), 32'h0);
      #9;
      rst_b = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (ack) ack_seen++;
      end
      chk("r_no_ack", 32'(ack_seen), 32'h0);
      chk("r_lvl_after", 32'(lvl), 32'h0);
      chk("r_sum_after", 32'(sum), 32'h0);
      chk("r_cnt_after", 32'(cnt), 32'h0);
      chk("r_busy_after", 32'(busy), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
